pci_wb_fifo_slave: RTL and testbench

Wishbone slave that sits directly downstream of the PCI target's Wishbone master port. It terminates the WB_STB/WB_WE/WB_ADD/WB_DATA strobes that the memory-space manager issues per PCI memory data phase, and returns WB_ACK/WB_VALID/WB_DATA. It provides a small register file plus a host-to-local TX FIFO and a local-to-host RX FIFO, with a level-based interrupt request feeding INTA.

---
 rtl/pci_wb_fifo_pkg.sv | 28 ++
 rtl/pci_wb_sync_fifo.sv | 69 ++++++
 rtl/pci_wb_fifo_slave.sv | 194 +++++++++++++++++++
 tb/tb_pci_wb_fifo_slave.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_wb_fifo_pkg.sv
// Shared definitions for the PCI-side Wishbone FIFO slave: register map,
// CTRL/STATUS bit positions and the bus handshake state encoding.
package pci_wb_fifo_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_TX_DATA = 3'd2;
    localparam logic [2:0] REG_RX_DATA = 3'd3;
    localparam logic [2:0] REG_SCRATCH = 3'd4;

    localparam int CTRL_TX_EN     = 0;
    localparam int CTRL_RX_IRQ_EN = 1;
    localparam int CTRL_TX_FLUSH  = 2;
    localparam int CTRL_RX_FLUSH  = 3;

    localparam int STAT_RX_COUNT_LSB = 8;
    localparam int STAT_TX_OVF       = 16;
    localparam int STAT_RX_UNF       = 17;
    localparam int STAT_TX_FULL      = 18;
    localparam int STAT_RX_EMPTY     = 19;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } bus_state_e;

endpackage

// File: rtl/pci_wb_sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush. A push on a full FIFO is
// accepted only when a pop happens in the same cycle; flush overrides both.
module pci_wb_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full  = count_q[DEPTH_LOG2];
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
            else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/pci_wb_fifo_slave.sv
// Wishbone slave behind the PCI target: register file, host-to-local TX FIFO,
// local-to-host RX FIFO and a registered level interrupt request.
module pci_wb_fifo_slave
    import pci_wb_fifo_pkg::*;
#(
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter int          RX_IRQ_LEVEL    = 4,
    parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000
) (
    input  logic        PHY_CLK33_I,
    input  logic        PHY_RST_I,
    input  logic        WB_STB_I,
    input  logic        WB_WE_I,
    input  logic [31:0] WB_ADD_I,
    input  logic [31:0] WB_DATA_I,
    output logic [31:0] WB_DATA_O,
    output logic        WB_ACK_O,
    output logic        WB_VALID_O,
    output logic [31:0] TX_DATA_O,
    output logic        TX_VALID_O,
    input  logic        TX_READY_I,
    input  logic [31:0] RX_DATA_I,
    input  logic        RX_VALID_I,
    output logic        RX_READY_O,
    output logic        IRQ_O
);
    localparam int            CW          = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] IRQ_LEVEL_C = CW'(RX_IRQ_LEVEL);

    bus_state_e  state_q, state_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_unf_q, rx_unf_d;
    logic [31:0] scratch_q, scratch_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic [2:0]    reg_sel;
    logic          access;
    logic [31:0]   status;
    logic          unused_addr_bits;

    logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty, tx_valid;
    logic [31:0]   tx_head;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [31:0]   rx_head;
    logic [CW-1:0] rx_count;

    assign reg_sel          = WB_ADD_I[4:2];
    assign unused_addr_bits = ^{WB_ADD_I[31:5], WB_ADD_I[1:0]};
    assign access           = (state_q == ST_IDLE) && WB_STB_I;

    assign tx_valid = ctrl_q[CTRL_TX_EN] && !tx_empty;
    assign tx_pop   = tx_valid && TX_READY_I;
    assign rx_push  = RX_VALID_I && !rx_full;

    assign WB_ACK_O   = (state_q == ST_ACK);
    assign WB_VALID_O = valid_q;
    assign WB_DATA_O  = rdata_q;
    assign TX_VALID_O = tx_valid;
    assign TX_DATA_O  = tx_valid ? tx_head : '0;
    assign RX_READY_O = !rx_full && !PHY_RST_I;
    assign IRQ_O      = irq_q;

    pci_wb_sync_fifo #(.WIDTH(32), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .clk   (PHY_CLK33_I),
        .rst   (PHY_RST_I),
        .flush (tx_flush),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (WB_DATA_I),
        .rdata (tx_head),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    pci_wb_sync_fifo #(.WIDTH(32), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .clk   (PHY_CLK33_I),
        .rst   (PHY_RST_I),
        .flush (rx_flush),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (RX_DATA_I),
        .rdata (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        status                                = '0;
        status[CW-1:0]                        = tx_count;
        status[STAT_RX_COUNT_LSB +: CW]       = rx_count;
        status[STAT_TX_OVF]                   = tx_ovf_q;
        status[STAT_RX_UNF]                   = rx_unf_q;
        status[STAT_TX_FULL]                  = tx_full;
        status[STAT_RX_EMPTY]                 = rx_empty;
    end

    // The access takes effect on the edge that enters ACK; its response is
    // registered so ACK, VALID and DATA appear together one cycle after STB.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        tx_ovf_d  = tx_ovf_q;
        rx_unf_d  = rx_unf_q;
        scratch_d = scratch_q;
        valid_d   = 1'b0;
        rdata_d   = '0;
        tx_push   = 1'b0;
        rx_pop    = 1'b0;
        tx_flush  = 1'b0;
        rx_flush  = 1'b0;
        irq_d     = ctrl_q[CTRL_RX_IRQ_EN] && (rx_count >= IRQ_LEVEL_C);

        case (state_q)
            ST_IDLE:     if (WB_STB_I) state_d = ST_ACK;
            ST_ACK:      state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!WB_STB_I) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        if (access) begin
            valid_d = 1'b1;
            if (WB_WE_I) begin
                case (reg_sel)
                    REG_CTRL: begin
                        ctrl_d[CTRL_TX_EN]     = WB_DATA_I[CTRL_TX_EN];
                        ctrl_d[CTRL_RX_IRQ_EN] = WB_DATA_I[CTRL_RX_IRQ_EN];
                        tx_flush               = WB_DATA_I[CTRL_TX_FLUSH];
                        rx_flush               = WB_DATA_I[CTRL_RX_FLUSH];
                    end
                    REG_STATUS: begin
                        if (WB_DATA_I[STAT_TX_OVF]) tx_ovf_d = 1'b0;
                        if (WB_DATA_I[STAT_RX_UNF]) rx_unf_d = 1'b0;
                    end
                    REG_TX_DATA: begin
                        // A local pop in the same cycle frees the slot for this word.
                        if (!tx_full || tx_pop) begin
                            tx_push = 1'b1;
                        end else begin
                            tx_ovf_d = 1'b1;
                            valid_d  = 1'b0;
                        end
                    end
                    REG_SCRATCH: scratch_d = WB_DATA_I;
                    default: ;
                endcase
            end else begin
                case (reg_sel)
                    REG_CTRL:   rdata_d = {30'b0, ctrl_q};
                    REG_STATUS: rdata_d = status;
                    REG_RX_DATA: begin
                        if (!rx_empty) begin
                            rx_pop  = 1'b1;
                            rdata_d = rx_head;
                        end else begin
                            rx_unf_d = 1'b1;
                            valid_d  = 1'b0;
                        end
                    end
                    REG_SCRATCH: rdata_d = scratch_q;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge PHY_CLK33_I) begin
        if (PHY_RST_I) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            tx_ovf_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
            scratch_q <= SCRATCH_RESET;
            valid_q   <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_unf_q  <= rx_unf_d;
            scratch_q <= scratch_d;
            valid_q   <= valid_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_pci_wb_fifo_slave.sv
// Bench for pci_wb_fifo_slave: directed scenarios plus a randomized phase,
// checked against a queue-based model of the register map and both FIFOs.
module tb_pci_wb_fifo_slave;
    localparam int          DEPTH   = 16;
    localparam int          IRQ_LVL = 4;
    localparam logic [31:0] SCR_RST = 32'h1234_5678;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_TX      = 3'd2;
    localparam logic [2:0] OFF_RX      = 3'd3;
    localparam logic [2:0] OFF_SCRATCH = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_stb, wb_we;
    logic [31:0] wb_add, wb_wdata, wb_rdata;
    logic        wb_ack, wb_valid;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, rx_ready;
    logic        irq;

    always #5 clk = ~clk;

    pci_wb_fifo_slave #(
        .FIFO_DEPTH_LOG2 (4),
        .RX_IRQ_LEVEL    (IRQ_LVL),
        .SCRATCH_RESET   (SCR_RST)
    ) dut (
        .PHY_CLK33_I (clk),
        .PHY_RST_I   (rst),
        .WB_STB_I    (wb_stb),
        .WB_WE_I     (wb_we),
        .WB_ADD_I    (wb_add),
        .WB_DATA_I   (wb_wdata),
        .WB_DATA_O   (wb_rdata),
        .WB_ACK_O    (wb_ack),
        .WB_VALID_O  (wb_valid),
        .TX_DATA_O   (tx_data),
        .TX_VALID_O  (tx_valid),
        .TX_READY_I  (tx_ready),
        .RX_DATA_I   (rx_data),
        .RX_VALID_I  (rx_valid),
        .RX_READY_O  (rx_ready),
        .IRQ_O       (irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic        m_tx_en, m_irq_en, m_tx_ovf, m_rx_unf;
    logic [31:0] m_scratch;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_tx_en   = 1'b0;
        m_irq_en  = 1'b0;
        m_tx_ovf  = 1'b0;
        m_rx_unf  = 1'b0;
        m_scratch = SCR_RST;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[4:0]   = 5'(tx_q.size());
        s[12:8]  = 5'(rx_q.size());
        s[16]    = m_tx_ovf;
        s[17]    = m_rx_unf;
        s[18]    = (tx_q.size() == DEPTH);
        s[19]    = (rx_q.size() == 0);
        return s;
    endfunction

    task automatic wb_xfer(input logic we, input logic [2:0] off, input logic [31:0] wd,
                           input logic pop_tx, output logic [31:0] rd, output logic vld);
        int lat;
        @(negedge clk);
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_add   = {27'($urandom), off, 2'($urandom)};
        wb_wdata = wd;
        tx_ready = pop_tx;
        lat = 0;
        while (wb_ack !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        tx_ready = 1'b0;
        check("ack_latency", 32'(lat), 32'd1);
        rd     = wb_rdata;
        vld    = wb_valid;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 32'(wb_ack), 32'd0);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [31:0] d, input string tag);
        logic [31:0] rd;
        logic        vld, exp_v;
        exp_v = 1'b1;
        case (off)
            OFF_CTRL: begin
                m_tx_en  = d[0];
                m_irq_en = d[1];
                if (d[2]) tx_q.delete();
                if (d[3]) rx_q.delete();
            end
            OFF_STATUS: begin
                if (d[16]) m_tx_ovf = 1'b0;
                if (d[17]) m_rx_unf = 1'b0;
            end
            OFF_TX: begin
                if (tx_q.size() < DEPTH) tx_q.push_back(d);
                else begin
                    m_tx_ovf = 1'b1;
                    exp_v    = 1'b0;
                end
            end
            OFF_SCRATCH: m_scratch = d;
            default: ;
        endcase
        wb_xfer(1'b1, off, d, 1'b0, rd, vld);
        check({tag, "_valid"}, 32'(vld), 32'(exp_v));
    endtask

    task automatic bus_read(input logic [2:0] off, input string tag);
        logic [31:0] rd, exp_d;
        logic        vld, exp_v;
        exp_v = 1'b1;
        exp_d = '0;
        case (off)
            OFF_CTRL:    exp_d = {30'b0, m_irq_en, m_tx_en};
            OFF_STATUS:  exp_d = exp_status();
            OFF_RX: begin
                if (rx_q.size() > 0) exp_d = rx_q.pop_front();
                else begin
                    m_rx_unf = 1'b1;
                    exp_v    = 1'b0;
                end
            end
            OFF_SCRATCH: exp_d = m_scratch;
            default: ;
        endcase
        wb_xfer(1'b0, off, $urandom, 1'b0, rd, vld);
        check({tag, "_valid"}, 32'(vld), 32'(exp_v));
        check({tag, "_data"}, rd, exp_d);
    endtask

    task automatic local_rx_push(input logic [31:0] d);
        @(negedge clk);
        check("rx_ready", 32'(rx_ready), 32'(rx_q.size() < DEPTH));
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
        if (rx_q.size() < DEPTH) rx_q.push_back(d);
    endtask

    task automatic local_tx_pop();
        logic exp_v;
        exp_v = m_tx_en && (tx_q.size() > 0);
        @(negedge clk);
        check("tx_valid", 32'(tx_valid), 32'(exp_v));
        if (exp_v) check("tx_data", tx_data, tx_q[0]);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        if (exp_v) void'(tx_q.pop_front());
    endtask

    task automatic check_side();
        check("side_irq", 32'(irq), 32'(m_irq_en && (rx_q.size() >= IRQ_LVL)));
        check("side_tx_valid", 32'(tx_valid), 32'(m_tx_en && (tx_q.size() > 0)));
        check("side_rx_ready", 32'(rx_ready), 32'(rx_q.size() < DEPTH));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        vld;
        int          acks, first;

        rst = 1'b1; wb_stb = 1'b0; wb_we = 1'b0; wb_add = '0; wb_wdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_valid", 32'(wb_valid), 32'd0);
        check("rst_rdata", wb_rdata, 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;

        // Reset state through the bus
        bus_read(OFF_STATUS, "status_reset");
        check("status_reset_const", exp_status(), 32'h0008_0000);
        bus_read(OFF_SCRATCH, "scratch_reset");
        check_side();

        // SCRATCH write/readback and a long STB producing a single ACK
        bus_write(OFF_SCRATCH, 32'hDEADBEEF, "scratch_wr");
        bus_read(OFF_SCRATCH, "scratch_rd");
        @(negedge clk);
        wb_stb = 1'b1; wb_we = 1'b0; wb_add = {27'h0, OFF_SCRATCH, 2'b00};
        acks = 0; rd = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb_ack) begin
                acks++;
                rd = wb_rdata;
            end
        end
        wb_stb = 1'b0;
        repeat (2) @(negedge clk);
        check("long_stb_acks", 32'(acks), 32'd1);
        check("long_stb_data", rd, 32'hDEADBEEF);

        // Fill TX with tx_en = 0, overflow on the 17th write
        for (int i = 0; i < DEPTH + 1; i++) bus_write(OFF_TX, $urandom, "tx_fill");
        bus_read(OFF_STATUS, "status_tx_full");
        bus_write(OFF_STATUS, 32'h0001_0000, "status_w1c");
        bus_read(OFF_STATUS, "status_ovf_clr");

        // Enable TX and drain one word per cycle
        bus_write(OFF_CTRL, 32'h1, "ctrl_tx_en");
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_valid", 32'(tx_valid), 32'd1);
            check("drain_data", tx_data, tx_q[0]);
            @(negedge clk);
            void'(tx_q.pop_front());
        end
        tx_ready = 1'b0;
        check("drain_empty", 32'(tx_valid), 32'd0);

        // RX interrupt threshold and underflow
        bus_write(OFF_CTRL, 32'h2, "ctrl_irq_en");
        for (int i = 0; i < IRQ_LVL; i++) begin
            check("irq_below_level", 32'(irq), 32'd0);
            local_rx_push($urandom);
        end
        check("irq_latency", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_rise", 32'(irq), 32'd1);
        bus_read(OFF_RX, "rx_pop1");
        check("irq_fall", 32'(irq), 32'd0);
        for (int i = 0; i < 3; i++) bus_read(OFF_RX, "rx_pop");
        bus_read(OFF_RX, "rx_underflow");
        bus_read(OFF_STATUS, "status_rx_unf");

        // RX full: 17th local push refused
        for (int i = 0; i < DEPTH + 1; i++) local_rx_push($urandom);
        @(negedge clk);
        check_side();
        bus_read(OFF_RX, "rx_after_full");
        bus_write(OFF_CTRL, 32'h8, "ctrl_rx_flush");
        bus_read(OFF_STATUS, "status_rx_flushed");

        // Simultaneous WB push and local pop on a full TX FIFO
        for (int i = 0; i < DEPTH; i++) bus_write(OFF_TX, $urandom, "tx_refill");
        bus_write(OFF_CTRL, 32'h1, "ctrl_tx_en2");
        rd = $urandom;
        void'(tx_q.pop_front());
        tx_q.push_back(rd);
        wb_xfer(1'b1, OFF_TX, rd, 1'b1, rd, vld);
        check("push_pop_full_valid", 32'(vld), 32'd1);
        bus_read(OFF_STATUS, "status_push_pop_full");
        local_tx_pop();

        // Flush concurrent with a local pop
        tx_q.delete();
        m_tx_en = 1'b1;
        wb_xfer(1'b1, OFF_CTRL, 32'h5, 1'b1, rd, vld);
        check("flush_pop_valid", 32'(vld), 32'd1);
        bus_read(OFF_STATUS, "status_flush_pop");
        bus_read(OFF_CTRL, "ctrl_self_clear");

        // Reset asserted in the access cycle, STB held across release
        bus_write(OFF_SCRATCH, 32'hCAFE_F00D, "scratch_pre_rst");
        @(negedge clk);
        wb_stb = 1'b1; wb_we = 1'b0; wb_add = {27'h0, OFF_SCRATCH, 2'b00};
        rst = 1'b1;
        @(negedge clk);
        check("rst_ack_suppressed", 32'(wb_ack), 32'd0);
        rst = 1'b0;
        model_reset();
        acks = 0; first = -1; rd = '0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (wb_ack) begin
                acks++;
                if (first < 0) begin
                    first = i;
                    rd    = wb_rdata;
                end
            end
        end
        wb_stb = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_acks", 32'(acks), 32'd1);
        check("post_rst_latency", 32'(first), 32'd1);
        check("post_rst_data", rd, SCR_RST);
        check_side();

        // Randomized mix against the model
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: bus_write(OFF_SCRATCH, $urandom, "r_scratch_wr");
                1: bus_read(OFF_SCRATCH, "r_scratch_rd");
                2: bus_write(OFF_TX, $urandom, "r_tx_wr");
                3: bus_read(OFF_RX, "r_rx_rd");
                4: local_rx_push($urandom);
                5: local_tx_pop();
                6: bus_read(OFF_STATUS, "r_status");
                7: bus_write(OFF_CTRL,
                             {28'h0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                              1'($urandom), 1'($urandom)}, "r_ctrl_wr");
                8: bus_write(OFF_STATUS, $urandom, "r_status_w1c");
                default: begin
                    if ($urandom_range(0, 1) == 1)
                        bus_write(3'(5 + $urandom_range(0, 2)), $urandom, "r_hole_wr");
                    else
                        bus_read(3'(5 + $urandom_range(0, 2)), "r_hole_rd");
                    if ($urandom_range(0, 1) == 1) bus_read(OFF_TX, "r_tx_rd");
                    else bus_write(OFF_RX, $urandom, "r_rx_wr");
                end
            endcase
            @(negedge clk);
            check_side();
        end
        bus_read(OFF_STATUS, "final_status");
        bus_read(OFF_CTRL, "final_ctrl");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
